edu_token_slide_seq: RTL

//  Sequential, parametrised token-setup engine for the fastsliding EDU.
//  - Accepts one token (exist, column, direction, flag mode) per request.
//  - Emits one token_set / flag_set beat per unit-cell row for NUM_ROW rows.
//  - The token slides one column per row.
//  - Generalises the single-row row-2 setup to N rows, with handshakes, direction, flag polarity and flush.

---
 rtl/edu_token_slide_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/edu_token_slide_seq.sv
// Token-setup engine for the fastsliding EDU: one accepted token becomes NUM_ROW
// registered beats, with the token sliding one column per row.
module edu_token_slide_seq #(
  parameter int NUM_UCROW = 4,
  parameter int NUM_ROW   = 4,
  parameter int COLW      = $clog2(2*NUM_UCROW) + 1,
  parameter int RIDW      = ($clog2(NUM_ROW) > 0) ? $clog2(NUM_ROW) : 1,
  localparam int W        = 2*NUM_UCROW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_token_exist,
  input  logic [COLW-1:0] in_token_col,
  input  logic            in_dir,
  input  logic            in_flag_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_token_set,
  output logic [W-1:0]    out_flag_set,
  output logic [RIDW-1:0] out_row,
  output logic            out_last,
  output logic            out_lost,
  output logic            out_err
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  localparam logic signed [COLW:0] COL_ONE  = 1;
  localparam logic [RIDW-1:0]      ROW_LAST = RIDW'(NUM_ROW - 1);

  state_t                 state, state_n;
  logic signed [COLW:0]   col_q, col_n;
  logic [RIDW-1:0]        row_q, row_n;
  logic                   exist_q, exist_n, dir_q, dir_n, mode_q, mode_n;
  logic                   valid_q, valid_n, last_q, last_n;
  logic                   lost_q, lost_n, err_q, err_n;
  logic [W-1:0]           tok_q, tok_n, flag_q, flag_n;

  function automatic logic in_range(input logic signed [COLW:0] c);
    int ci;
    ci = int'(c);
    return (ci >= 0) && (ci <= W - 1);
  endfunction

  function automatic logic [W-1:0] token_of(input logic signed [COLW:0] c);
    logic [W-1:0] t;
    int ci;
    ci = int'(c);
    for (int i = 0; i < W; i++) t[i] = (i == ci);
    return t;
  endfunction

  // mode 0 fills from bit 0 up to the token, mode 1 from the token up to the MSB
  function automatic logic [W-1:0] flag_of(input logic signed [COLW:0] c, input logic mode);
    logic [W-1:0] f;
    int ci;
    ci = int'(c);
    for (int i = 0; i < W; i++) f[i] = mode ? (i >= ci) : (i <= ci);
    return f;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_n  = state;
    col_n    = col_q;
    row_n    = row_q;
    exist_n  = exist_q;
    dir_n    = dir_q;
    mode_n   = mode_q;
    valid_n  = valid_q;
    last_n   = last_q;
    lost_n   = lost_q;
    err_n    = err_q;
    tok_n    = '0;
    flag_n   = '0;
    in_ready = (state == S_IDLE);

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          col_n   = {in_token_col[COLW-1], in_token_col};
          exist_n = in_token_exist;
          dir_n   = in_dir;
          mode_n  = in_flag_mode;
          err_n   = in_token_exist && (int'(in_token_col) >= W);
          lost_n  = !in_token_exist || err_n || !in_range(col_n);
          row_n   = '0;
          last_n  = (ROW_LAST == '0);
          valid_n = 1'b1;
          state_n = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (row_q == ROW_LAST) begin
            row_n   = '0;
            valid_n = 1'b0;
            last_n  = 1'b0;
            lost_n  = 1'b0;
            err_n   = 1'b0;
            state_n = S_IDLE;
          end else begin
            row_n  = row_q + RIDW'(1);
            col_n  = dir_q ? col_q - COL_ONE : col_q + COL_ONE;
            // once the token leaves the patch it never re-enters
            lost_n = lost_q || !in_range(col_n);
            last_n = (row_n == ROW_LAST);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (valid_n && !lost_n) begin
      tok_n  = token_of(col_n);
      flag_n = flag_of(col_n, mode_n);
    end

    // flush wins over any handshake or accept in the same cycle
    if (flush) begin
      state_n = S_IDLE;
      col_n   = '0;
      row_n   = '0;
      exist_n = 1'b0;
      dir_n   = 1'b0;
      mode_n  = 1'b0;
      valid_n = 1'b0;
      last_n  = 1'b0;
      lost_n  = 1'b0;
      err_n   = 1'b0;
      tok_n   = '0;
      flag_n  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      exist_q <= 1'b0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      lost_q  <= 1'b0;
      err_q   <= 1'b0;
      tok_q   <= '0;
      flag_q  <= '0;
    end else begin
      state   <= state_n;
      col_q   <= col_n;
      row_q   <= row_n;
      exist_q <= exist_n;
      dir_q   <= dir_n;
      mode_q  <= mode_n;
      valid_q <= valid_n;
      last_q  <= last_n;
      lost_q  <= lost_n;
      err_q   <= err_n;
      tok_q   <= tok_n;
      flag_q  <= flag_n;
    end
  end

  assign out_valid     = valid_q;
  assign out_token_set = tok_q;
  assign out_flag_set  = flag_q;
  assign out_row       = row_q;
  assign out_last      = last_q;
  assign out_lost      = lost_q;
  assign out_err       = err_q;

endmodule
